// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_e        : arbiter FSM states (IDLE, BUSY)
//   DMEM_TIMEOUT_RDATA : read data returned to a master whose access timed out
//   dmem_req_t         : captured request (write, wstrb, addr, wdata) at the
//                        default 32-bit data-memory width
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DMEM_XLEN   = 32;
  localparam int DMEM_STRB_W = DMEM_XLEN / 8;

  localparam logic [31:0] DMEM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                   write;
    logic [DMEM_STRB_W-1:0] wstrb;
    logic [DMEM_XLEN-1:0]   addr;
    logic [DMEM_XLEN-1:0]   wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_rr_picker.sv
// -----------------------------------------------------------------------------
// dmem_rr_picker
// Combinational round-robin selector: scans the request vector starting at
// ptr and wrapping from N-1 back to 0, returning the first requester.
//   req  in  N   request vector
//   ptr  in  IW  scan start index (0..N-1)
//   any  out 1   at least one request is set
//   idx  out IW  index of the winning request (0 when any=0)
// -----------------------------------------------------------------------------
module dmem_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      // Modulo by subtraction: ptr + k never exceeds 2N-2, and N need not
      // be a power of two.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// N-to-1 round-robin arbiter from several dmem masters onto one dmem slave.
// The winning request is registered so the slave sees stable signals for the
// whole transaction; completion is passed back combinationally.
//
// Optional feature macro: DMEM_ARB_TIMEOUT_EN enables a BUSY watchdog that
// completes a hung access after TIMEOUT_CYCLES cycles with DEAD_BEEF read
// data and a one-cycle err_timeout pulse.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   m_valid/m_write   per-master request and write flag     [NUM_PORTS]
//   m_wstrb           packed strobes, master i at [i*STRB_W +: STRB_W]
//   m_addr/m_wdata    packed address / write data, master i at [i*XLEN +: XLEN]
//   m_ready           one-hot completion to the granted master
//   m_rdata           shared read data, valid alongside its m_ready bit
//   s_valid..s_wdata  registered downstream request
//   s_rdata/s_ready   downstream read data and completion
//   err_timeout       one-cycle watchdog pulse (0 without the macro)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_PORTS      = 2,
  parameter int STRB_W         = XLEN / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        m_valid,
  input  logic [NUM_PORTS-1:0]        m_write,
  input  logic [NUM_PORTS*STRB_W-1:0] m_wstrb,
  input  logic [NUM_PORTS*XLEN-1:0]   m_addr,
  input  logic [NUM_PORTS*XLEN-1:0]   m_wdata,
  output logic [NUM_PORTS-1:0]        m_ready,
  output logic [XLEN-1:0]             m_rdata,
  output logic                        s_valid,
  output logic                        s_write,
  output logic [STRB_W-1:0]           s_wstrb,
  output logic [XLEN-1:0]             s_addr,
  output logic [XLEN-1:0]             s_wdata,
  input  logic [XLEN-1:0]             s_rdata,
  input  logic                        s_ready,
  output logic                        err_timeout
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef struct packed {
    logic              write;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } req_t;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, ptr_q, pick_idx;
  logic             pick_any;
  req_t             req_q, pick_req;
  logic             busy, done, timeout_fire;

  dmem_rr_picker #(
    .N  (NUM_PORTS),
    .IW (IDX_W)
  ) u_picker (
    .req (m_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Fields of the current round-robin winner, ready to be captured.
  always_comb begin
    pick_req.write = m_write[pick_idx];
    pick_req.wstrb = m_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
    pick_req.addr  = m_addr[int'(pick_idx)*XLEN +: XLEN];
    pick_req.wdata = m_wdata[int'(pick_idx)*XLEN +: XLEN];
  end

  assign busy = (state_q == BUSY);
  assign done = busy && (s_ready || timeout_fire);

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt_q;

  // Held at zero while IDLE, so every transaction starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wd_cnt_q <= '0;
    else if (!busy)      wd_cnt_q <= '0;
    else if (!s_ready)   wd_cnt_q <= wd_cnt_q + 1'b1;
  end

  // A real s_ready in the limit cycle takes precedence over the watchdog.
  assign timeout_fire = busy && !s_ready &&
                        (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign timeout_fire       = 1'b0;
  // Keeps the watchdog limit referenced when the watchdog is compiled out.
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: the reset branch clears the FSM and every data register, so the
  // registered s_* outputs are 0 straight out of reset, not just s_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
      req_q   <= '0;
    end else if (state_q == IDLE && pick_any) begin
      grant_q <= pick_idx;
      req_q   <= pick_req;
    end else if (done) begin
      ptr_q <= (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  // Downstream request is only presented while BUSY; m_rdata is forced to 0
  // outside BUSY so stale slave data never reaches the masters.
  always_comb begin
    s_valid     = busy;
    s_write     = busy ? req_q.write : 1'b0;
    s_wstrb     = busy ? req_q.wstrb : '0;
    s_addr      = busy ? req_q.addr  : '0;
    s_wdata     = busy ? req_q.wdata : '0;
    m_ready     = done ? (NUM_PORTS'(1) << grant_q) : '0;
    m_rdata     = '0;
    if (busy) m_rdata = timeout_fire ? XLEN'(DMEM_TIMEOUT_RDATA) : s_rdata;
    err_timeout = timeout_fire;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter: a 4-port instance (single read, reset
// mid-transaction, contention, early drop, optional watchdog) and a 3-port
// instance (pointer wrap). Stimulus pushes expected transactions into a
// per-instance queue; a negedge monitor compares the slave-side request each
// BUSY cycle and the completion when m_ready is seen.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-port instance
  logic [3:0]   a_valid, a_write, a_m_ready;
  logic [15:0]  a_wstrb;
  logic [127:0] a_addr, a_wdata;
  logic [31:0]  a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic [3:0]   a_s_wstrb;
  logic         a_s_valid, a_s_write, a_s_ready, a_err;

  // 3-port instance
  logic [2:0]   b_valid, b_write, b_m_ready;
  logic [11:0]  b_wstrb;
  logic [95:0]  b_addr, b_wdata;
  logic [31:0]  b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic [3:0]   b_s_wstrb;
  logic         b_s_valid, b_s_write, b_s_ready, b_err;

  dmem_arbiter #(.XLEN(32), .NUM_PORTS(4), .TIMEOUT_CYCLES(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .m_valid(a_valid), .m_write(a_write), .m_wstrb(a_wstrb),
    .m_addr(a_addr), .m_wdata(a_wdata),
    .m_ready(a_m_ready), .m_rdata(a_m_rdata),
    .s_valid(a_s_valid), .s_write(a_s_write), .s_wstrb(a_s_wstrb),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_rdata(a_s_rdata), .s_ready(a_s_ready), .err_timeout(a_err)
  );

  dmem_arbiter #(.XLEN(32), .NUM_PORTS(3), .TIMEOUT_CYCLES(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .m_valid(b_valid), .m_write(b_write), .m_wstrb(b_wstrb),
    .m_addr(b_addr), .m_wdata(b_wdata),
    .m_ready(b_m_ready), .m_rdata(b_m_rdata),
    .s_valid(b_s_valid), .s_write(b_s_write), .s_wstrb(b_s_wstrb),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_rdata(b_s_rdata), .s_ready(b_s_ready), .err_timeout(b_err)
  );

  typedef struct {
    int          port;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(int p, logic w, logic [3:0] st, logic [31:0] ad,
                              logic [31:0] wd, logic [31:0] rd, logic to);
    exp_t e;
    e.port = p; e.write = w; e.wstrb = st; e.addr = ad;
    e.wdata = wd; e.rdata = rd; e.to = to;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  task automatic mon(int inst, logic sv, logic sw, logic [3:0] sst,
                     logic [31:0] sad, logic [31:0] swd, logic [3:0] mr,
                     logic [31:0] mrd, logic err);
    exp_t e;
    bit   have = 1'b0;
    if (inst == 0 && qa.size() > 0) begin e = qa[0]; have = 1'b1; end
    if (inst == 1 && qb.size() > 0) begin e = qb[0]; have = 1'b1; end
    if (!sv) begin
      check($sformatf("p%0d_idle_ready_err", inst), {mr, err}, 0);
    end else if (!have) begin
      total++;
      bad++;
      $display("FAIL p%0d_unexpected_busy: got s_valid=1 addr=%0h, want no transaction",
               inst, sad);
    end else begin
      check($sformatf("p%0d_s_write", inst), sw,  e.write);
      check($sformatf("p%0d_s_wstrb", inst), sst, e.wstrb);
      check($sformatf("p%0d_s_addr", inst),  sad, e.addr);
      check($sformatf("p%0d_s_wdata", inst), swd, e.wdata);
      if (mr != 0) begin
        check($sformatf("p%0d_m_ready", inst), mr,  4'(1) << e.port);
        check($sformatf("p%0d_m_rdata", inst), mrd, e.rdata);
        check($sformatf("p%0d_err_timeout", inst), err, e.to);
        if (inst == 0) void'(qa.pop_front());
        else           void'(qb.pop_front());
      end else begin
        check($sformatf("p%0d_err_early", inst), err, 1'b0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, a_s_valid, a_s_write, a_s_wstrb, a_s_addr, a_s_wdata,
          a_m_ready, a_m_rdata, a_err);
      mon(1, b_s_valid, b_s_write, b_s_wstrb, b_s_addr, b_s_wdata,
          {1'b0, b_m_ready}, b_m_rdata, b_err);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(int p, logic w, logic [3:0] st, logic [31:0] ad, logic [31:0] wd);
    a_valid[p] = 1'b1;
    a_write[p] = w;
    a_wstrb[p*4 +: 4]   = st;
    a_addr[p*32 +: 32]  = ad;
    a_wdata[p*32 +: 32] = wd;
  endtask

  task automatic b_req(int p, logic w, logic [3:0] st, logic [31:0] ad, logic [31:0] wd);
    b_valid[p] = 1'b1;
    b_write[p] = w;
    b_wstrb[p*4 +: 4]   = st;
    b_addr[p*32 +: 32]  = ad;
    b_wdata[p*32 +: 32] = wd;
  endtask

  // Called from the first BUSY cycle: ws wait states, then one ready cycle.
  task automatic serve(int inst, int ws, logic [31:0] rd);
    repeat (ws) tick();
    if (inst == 0) begin a_s_ready = 1'b1; a_s_rdata = rd; end
    else           begin b_s_ready = 1'b1; b_s_rdata = rd; end
    tick();
    if (inst == 0) a_s_ready = 1'b0;
    else           b_s_ready = 1'b0;
  endtask

  task automatic wait_ready(int inst, output int p);
    logic [3:0] mr;
    p = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      mr = (inst == 0) ? a_m_ready : {1'b0, b_m_ready};
      if (mr != 0) begin
        for (int k = 0; k < 4; k++) if (mr[k]) p = k;
        break;
      end
    end
    check($sformatf("p%0d_ready_within_30", inst), (p >= 0), 1'b1);
  endtask

  task automatic zero_a(string tag);
    check({tag, "_s_valid"}, a_s_valid, 1'b0);
    check({tag, "_s_write"}, a_s_write, 1'b0);
    check({tag, "_s_wstrb"}, a_s_wstrb, 4'h0);
    check({tag, "_s_addr"},  a_s_addr,  32'h0);
    check({tag, "_s_wdata"}, a_s_wdata, 32'h0);
    check({tag, "_m_ready"}, a_m_ready, 4'h0);
    check({tag, "_m_rdata"}, a_m_rdata, 32'h0);
    check({tag, "_err"},     a_err,     1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int p;
    int cyc;
    int order4 [5] = '{0, 1, 2, 3, 0};
    int order3a[2] = '{0, 2};
    int order3b[2] = '{1, 2};

    a_valid = '0; a_write = '0; a_wstrb = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_write = '0; b_wstrb = '0; b_addr = '0; b_wdata = '0;
    a_s_ready = 1'b1; a_s_rdata = 32'hFFFF_FFFF;
    b_s_ready = 1'b0; b_s_rdata = 32'h0;

    // Reset state: outputs 0 even with slave ready and nonzero read data.
    #12;
    zero_a("rst");
    a_s_ready = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single read, master 2, three wait states.
    tick();
    a_req(2, 1'b0, 4'hF, 32'h100, 32'h0);
    qa.push_back(mk(2, 1'b0, 4'hF, 32'h100, 32'h0, 32'hCAFE_0001, 1'b0));
    check("read_lat_before_edge", a_s_valid, 1'b0);
    tick();
    check("read_lat_after_edge", a_s_valid, 1'b1);
    serve(0, 3, 32'hCAFE_0001);
    a_valid[2] = 1'b0;
    check("read_drained", qa.size(), 0);

    // Reset while BUSY, then master 3 is granted.
    tick();
    a_req(0, 1'b1, 4'h1, 32'h500, 32'h55);
    qa.push_back(mk(0, 1'b1, 4'h1, 32'h500, 32'h55, 32'h0, 1'b0));
    a_s_rdata = 32'h7777_7777;
    tick();
    check("rstbusy_s_valid", a_s_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    zero_a("rstbusy");
    qa.delete();
    a_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    a_req(3, 1'b1, 4'h8, 32'h600, 32'h66);
    qa.push_back(mk(3, 1'b1, 4'h8, 32'h600, 32'h66, 32'h0, 1'b0));
    tick();
    serve(0, 1, 32'h0);
    a_valid[3] = 1'b0;
    check("post_rst_drained", qa.size(), 0);

    // Contention: pointer is 0 again after serving master 3.
    tick();
    a_s_rdata = 32'h1234_5678;
    a_s_ready = 1'b1;
    a_req(0, 1'b1, 4'b0011, 32'h1000, 32'hA0);
    a_req(1, 1'b1, 4'b1100, 32'h1004, 32'hA1);
    a_req(2, 1'b1, 4'b0001, 32'h1008, 32'hA2);
    a_req(3, 1'b1, 4'b1111, 32'h100C, 32'hA3);
    qa.push_back(mk(0, 1'b1, 4'b0011, 32'h1000, 32'hA0, 32'h1234_5678, 1'b0));
    qa.push_back(mk(1, 1'b1, 4'b1100, 32'h1004, 32'hA1, 32'h1234_5678, 1'b0));
    qa.push_back(mk(2, 1'b1, 4'b0001, 32'h1008, 32'hA2, 32'h1234_5678, 1'b0));
    qa.push_back(mk(3, 1'b1, 4'b1111, 32'h100C, 32'hA3, 32'h1234_5678, 1'b0));
    qa.push_back(mk(0, 1'b1, 4'b0110, 32'h1010, 32'hB0, 32'h1234_5678, 1'b0));
    for (int n = 0; n < 5; n++) begin
      wait_ready(0, p);
      check($sformatf("cont_order%0d", n), p, order4[n]);
      tick();
      if (p >= 0) a_valid[p] = 1'b0;
      if (n == 0) a_req(0, 1'b1, 4'b0110, 32'h1010, 32'hB0);
    end
    a_s_ready = 1'b0;
    check("cont_drained", qa.size(), 0);

    // Early drop: master 1 withdraws and changes its address after the grant.
    tick();
    a_req(1, 1'b0, 4'b1010, 32'h200, 32'h0);
    qa.push_back(mk(1, 1'b0, 4'b1010, 32'h200, 32'h0, 32'hBEEF_0002, 1'b0));
    tick();
    a_valid[1] = 1'b0;
    a_addr[32 +: 32] = 32'h999;
    serve(0, 2, 32'hBEEF_0002);
    check("drop_drained", qa.size(), 0);

`ifdef DMEM_ARB_TIMEOUT_EN
    // Watchdog: slave never ready; fires in the 8th BUSY cycle.
    tick();
    a_req(0, 1'b0, 4'hF, 32'h300, 32'h0);
    qa.push_back(mk(0, 1'b0, 4'hF, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1));
    tick();
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (a_m_ready != 0) break;
    end
    check("wd_fire_cycle", cyc, 8);
    tick();
    a_valid[0] = 1'b0;
    a_s_ready  = 1'b1;
    @(negedge clk);
    check("wd_late_ready_s_valid", a_s_valid, 1'b0);
    check("wd_late_ready_m_ready", a_m_ready, 4'h0);
    tick();
    a_s_ready = 1'b0;
    tick();
    check("wd_drained", qa.size(), 0);
`endif

    // 3-port wrap: serve master 2, then 0 and 2 contend from pointer 0.
    tick();
    b_req(2, 1'b1, 4'h1, 32'h40, 32'h22);
    qb.push_back(mk(2, 1'b1, 4'h1, 32'h40, 32'h22, 32'h0BB0_0000, 1'b0));
    tick();
    serve(1, 0, 32'h0BB0_0000);
    b_valid[2] = 1'b0;
    tick();
    b_s_ready = 1'b1;
    b_s_rdata = 32'h0BB0_0001;
    b_req(0, 1'b1, 4'h2, 32'h44, 32'h33);
    b_req(2, 1'b0, 4'h4, 32'h48, 32'h44);
    qb.push_back(mk(0, 1'b1, 4'h2, 32'h44, 32'h33, 32'h0BB0_0001, 1'b0));
    qb.push_back(mk(2, 1'b0, 4'h4, 32'h48, 32'h44, 32'h0BB0_0001, 1'b0));
    for (int n = 0; n < 2; n++) begin
      wait_ready(1, p);
      check($sformatf("wrap_order%0d", n), p, order3a[n]);
      tick();
      if (p >= 0) b_valid[p] = 1'b0;
    end
    b_req(1, 1'b1, 4'h8, 32'h4C, 32'h55);
    b_req(2, 1'b1, 4'hF, 32'h50, 32'h66);
    qb.push_back(mk(1, 1'b1, 4'h8, 32'h4C, 32'h55, 32'h0BB0_0001, 1'b0));
    qb.push_back(mk(2, 1'b1, 4'hF, 32'h50, 32'h66, 32'h0BB0_0001, 1'b0));
    for (int n = 0; n < 2; n++) begin
      wait_ready(1, p);
      check($sformatf("wrap2_order%0d", n), p, order3b[n]);
      tick();
      if (p >= 0) b_valid[p] = 1'b0;
    end
    b_s_ready = 1'b0;
    check("wrap_drained", qb.size(), 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish by 100000 time units, want finish");
    $fatal(1);
  end

endmodule
